// File: rtl/variable_flip_selector_k.sv
// variable_flip_selector_k
//
// Purpose: collects up to NSAT candidate variables of one clause. For each
// candidate it keeps the masked "broken-if-flipped" clause bits and their
// popcount (the break value). It then picks one candidate to flip, using
// this priority order:
//   1. zero break value (highest such index),
//   2. random walk (random_i[15:0] mod count) when noise is enabled and
//      random_i >= P,
//   3. greedy minimum break value (ties go to the highest index).
// The chosen result is held until the consumer takes it.
//
// Ports:
//   clk                  - single clock, rising edge
//   reset                - asynchronous reset, active low
//   cand_valid_i/ready_o - candidate handshake (ready only while collecting)
//   cand_last_i          - presented candidate is the last of its clause
//   clause_broken_i      - per-slot broken-if-flipped flags (MC bits)
//   mask_bits_i          - per-slot occupancy mask (MC bits)
//   noise_en_i           - random-walk selection enable
//   random_i             - 32-bit LFSR word
//   sel_valid_o/ready_i  - result handshake
//   selected_o           - chosen candidate index
//   break_value_o        - break value of the chosen candidate
//   clause_broken_bits_o - masked broken bits of the chosen candidate
module variable_flip_selector_k #(
    parameter int          MAX_CLAUSES_PER_VARIABLE      = 20,
    parameter int          NSAT                          = 3,
    parameter int          NSAT_BITS                     = 2,
    parameter int          MAX_CLAUSES_PER_VARIABLE_BITS = 5,
    parameter logic [31:0] P                             = 32'h6E147AE0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     cand_valid_i,
    output logic                                     cand_ready_o,
    input  logic                                     cand_last_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]      clause_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]      mask_bits_i,
    input  logic                                     noise_en_i,
    input  logic [31:0]                              random_i,
    output logic                                     sel_valid_o,
    input  logic                                     sel_ready_i,
    output logic [NSAT_BITS-1:0]                     selected_o,
    output logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0] break_value_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0]      clause_broken_bits_o
);

    localparam int MC    = MAX_CLAUSES_PER_VARIABLE;
    localparam int MCB   = MAX_CLAUSES_PER_VARIABLE_BITS;
    localparam int CNT_W = $clog2(NSAT + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DECIDE  = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [MC-1:0]        bits_q [NSAT];
    logic [MC-1:0]        bits_d [NSAT];
    logic [MCB-1:0]       bv_q [NSAT];
    logic [MCB-1:0]       bv_d [NSAT];
    logic [NSAT_BITS-1:0] selected_q, selected_d;
    logic [MCB-1:0]       break_value_q, break_value_d;
    logic [MC-1:0]        clause_bits_q, clause_bits_d;

    logic                 accept;
    logic [MC-1:0]        cand_bits;
    logic [MCB-1:0]       cand_bv;
    logic [CNT_W-1:0]     count_inc;

    logic                 have_zero;
    logic [NSAT_BITS-1:0] zero_idx;
    logic [NSAT_BITS-1:0] min_idx;
    logic [MCB-1:0]       min_bv;
    logic [15:0]          divisor;
    logic [NSAT_BITS-1:0] noise_idx;
    logic [NSAT_BITS-1:0] pick;

    assign cand_ready_o         = (state_q == COLLECT);
    assign sel_valid_o          = (state_q == OUTPUT);
    assign selected_o           = selected_q;
    assign break_value_o        = break_value_q;
    assign clause_broken_bits_o = clause_bits_q;

    assign accept    = cand_valid_i & cand_ready_o;
    assign cand_bits = clause_broken_i & mask_bits_i;
    // MCB is wide enough to hold MC, so the popcount never needs to saturate.
    assign cand_bv   = MCB'($countones(cand_bits));
    assign count_inc = count_q + CNT_W'(1);

    // Selection network. It looks only at slots below count. Both scans run in
    // ascending order and take ">=" style updates, so the highest qualifying
    // index wins.
    always_comb begin
        have_zero = 1'b0;
        zero_idx  = '0;
        min_idx   = '0;
        min_bv    = '1;
        for (int i = 0; i < NSAT; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (bv_q[i] == '0) begin
                    have_zero = 1'b1;
                    zero_idx  = NSAT_BITS'(i);
                end
                if (bv_q[i] <= min_bv) begin
                    min_bv  = bv_q[i];
                    min_idx = NSAT_BITS'(i);
                end
            end
        end
        // count is never zero in DECIDE; the guard only keeps the divider defined.
        divisor   = (count_q == '0) ? 16'd1 : 16'(count_q);
        noise_idx = NSAT_BITS'(random_i[15:0] % divisor);
        if (have_zero) begin
            pick = zero_idx;
        end else if (noise_en_i && (random_i >= P)) begin
            pick = noise_idx;
        end else begin
            pick = min_idx;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        bits_d        = bits_q;
        bv_d          = bv_q;
        selected_d    = selected_q;
        break_value_d = break_value_q;
        clause_bits_d = clause_bits_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int i = 0; i < NSAT; i++) begin
                        if (CNT_W'(i) == count_q) begin
                            bits_d[i] = cand_bits;
                            bv_d[i]   = cand_bv;
                        end
                    end
                    count_d = count_inc;
                    // A full clause closes even if cand_last_i was not raised.
                    if (cand_last_i || (count_inc == CNT_W'(NSAT))) begin
                        state_d = DECIDE;
                    end
                end
            end
            DECIDE: begin
                selected_d = pick;
                for (int i = 0; i < NSAT; i++) begin
                    if (NSAT_BITS'(i) == pick) begin
                        break_value_d = bv_q[i];
                        clause_bits_d = bits_q[i];
                    end
                end
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (sel_ready_i) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= COLLECT;
            count_q       <= '0;
            selected_q    <= '0;
            break_value_q <= '0;
            clause_bits_q <= '0;
            for (int i = 0; i < NSAT; i++) begin
                bits_q[i] <= '0;
                bv_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            selected_q    <= selected_d;
            break_value_q <= break_value_d;
            clause_bits_q <= clause_bits_d;
            for (int i = 0; i < NSAT; i++) begin
                bits_q[i] <= bits_d[i];
                bv_q[i]   <= bv_d[i];
            end
        end
    end

endmodule

// File: tb/tb_variable_flip_selector_k.sv
// tb_variable_flip_selector_k
//
// Purpose: testbench for variable_flip_selector_k with the default parameters
// (MC=20, NSAT=3). It runs the directed clause scenarios and then randomized
// clauses. Each result is compared against a behavioural selection model that
// lives inside the bench.
module tb_variable_flip_selector_k;

    localparam logic [31:0] P_TB = 32'h6E147AE0;

    logic        clk;
    logic        reset;
    logic        cand_valid_i;
    logic        cand_ready_o;
    logic        cand_last_i;
    logic [19:0] clause_broken_i;
    logic [19:0] mask_bits_i;
    logic        noise_en_i;
    logic [31:0] random_i;
    logic        sel_valid_o;
    logic        sel_ready_i;
    logic [1:0]  selected_o;
    logic [4:0]  break_value_o;
    logic [19:0] clause_broken_bits_o;

    int checks;
    int failures;

    logic [19:0] cb [3];
    logic [19:0] mk [3];
    int          exp_sel;
    int          exp_bv;
    logic [19:0] exp_bits;

    variable_flip_selector_k dut (
        .clk                  (clk),
        .reset                (reset),
        .cand_valid_i         (cand_valid_i),
        .cand_ready_o         (cand_ready_o),
        .cand_last_i          (cand_last_i),
        .clause_broken_i      (clause_broken_i),
        .mask_bits_i          (mask_bits_i),
        .noise_en_i           (noise_en_i),
        .random_i             (random_i),
        .sel_valid_o          (sel_valid_o),
        .sel_ready_i          (sel_ready_i),
        .selected_o           (selected_o),
        .break_value_o        (break_value_o),
        .clause_broken_bits_o (clause_broken_bits_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference selection rules, expressed directly from the zero /
    // noise / greedy priority order.
    function automatic int ref_select(input int n, input int bv [3], input bit ne, input logic [31:0] r);
        int best;
        for (int i = n - 1; i >= 0; i--) begin
            if (bv[i] == 0) return i;
        end
        if (ne && (r >= P_TB)) return int'(r[15:0]) % n;
        best = n - 1;
        for (int i = n - 2; i >= 0; i--) begin
            if (bv[i] < bv[best]) best = i;
        end
        return best;
    endfunction

    task automatic set_bv(input int k, input int v);
        mk[k] = 20'hFFFFF;
        cb[k] = (v == 0) ? 20'h0 : (20'hFFFFF >> (20 - v));
    endtask

    // Presents n candidates from cb/mk. Decoy noise/random values are driven
    // while collecting, and the real values only in the DECIDE cycle. The
    // result is then checked against the model.
    task automatic send_clause(input int n, input bit last_on_final, input bit ne, input logic [31:0] r);
        int bv [3];
        for (int k = 0; k < 3; k++) bv[k] = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_output("cand_ready_collect", 32'(cand_ready_o), 32'd1);
            cand_valid_i    = 1'b1;
            clause_broken_i = cb[k];
            mask_bits_i     = mk[k];
            cand_last_i     = (k == n - 1) ? last_on_final : 1'b0;
            noise_en_i      = ~ne;
            random_i        = ~r;
            bv[k]           = $countones(cb[k] & mk[k]);
        end
        @(negedge clk);
        cand_valid_i = 1'b0;
        cand_last_i  = 1'b0;
        noise_en_i   = ne;
        random_i     = r;
        check_output("valid_in_decide", 32'(sel_valid_o), 32'd0);
        check_output("ready_in_decide", 32'(cand_ready_o), 32'd0);
        exp_sel  = ref_select(n, bv, ne, r);
        exp_bv   = bv[exp_sel];
        exp_bits = cb[exp_sel] & mk[exp_sel];
        @(negedge clk);
        noise_en_i = ~ne;
        random_i   = $urandom;
        check_output("sel_valid", 32'(sel_valid_o), 32'd1);
        check_output("selected", 32'(selected_o), 32'(exp_sel));
        check_output("break_value", 32'(break_value_o), 32'(exp_bv));
        check_output("clause_bits", 32'(clause_broken_bits_o), 32'(exp_bits));
    endtask

    // Stalls for a number of cycles while the inputs toggle. The held
    // result must not move. The task then releases it and checks that
    // COLLECT resumes one edge later.
    task automatic finish_clause(input int stall);
        for (int s = 0; s < stall; s++) begin
            cand_valid_i    = 1'(($urandom));
            clause_broken_i = 20'($urandom);
            mask_bits_i     = 20'($urandom);
            @(negedge clk);
            check_output("stall_valid", 32'(sel_valid_o), 32'd1);
            check_output("stall_ready", 32'(cand_ready_o), 32'd0);
            check_output("stall_selected", 32'(selected_o), 32'(exp_sel));
            check_output("stall_bv", 32'(break_value_o), 32'(exp_bv));
            check_output("stall_bits", 32'(clause_broken_bits_o), 32'(exp_bits));
        end
        cand_valid_i = 1'b0;
        sel_ready_i  = 1'b1;
        @(negedge clk);
        sel_ready_i = 1'b0;
        check_output("resume_ready", 32'(cand_ready_o), 32'd1);
        check_output("resume_valid", 32'(sel_valid_o), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_valid"}, 32'(sel_valid_o), 32'd0);
        check_output({tag, "_selected"}, 32'(selected_o), 32'd0);
        check_output({tag, "_bv"}, 32'(break_value_o), 32'd0);
        check_output({tag, "_bits"}, 32'(clause_broken_bits_o), 32'd0);
        check_output({tag, "_ready"}, 32'(cand_ready_o), 32'd1);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        cand_valid_i    = 1'b0;
        cand_last_i     = 1'b0;
        clause_broken_i = '0;
        mask_bits_i     = '0;
        noise_en_i      = 1'b0;
        random_i        = '0;
        sel_ready_i     = 1'b0;

        #2 reset = 1'b0;
        #1 check_cleared("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // All masks zero: every bv is 0, so the highest index wins.
        for (int k = 0; k < 3; k++) begin
            mk[k] = 20'h0;
            cb[k] = 20'($urandom);
        end
        send_clause(3, 1'b1, 1'b0, 32'h0);
        check_output("allzero_sel_const", 32'(selected_o), 32'd2);
        finish_clause(0);

        // A zero override beats noise.
        set_bv(0, 4); set_bv(1, 0); set_bv(2, 3);
        send_clause(3, 1'b1, 1'b1, 32'hFFFFFFFF);
        check_output("zero_override_const", 32'(selected_o), 32'd1);
        finish_clause(1);

        // Greedy selection with a tie resolved to the highest index. cand_last_i
        // is not raised on the third candidate, so the full count closes the clause.
        set_bv(0, 1); set_bv(1, 3); set_bv(2, 1);
        send_clause(3, 1'b0, 1'b0, 32'h0);
        check_output("greedy_tie_const", 32'(selected_o), 32'd2);
        finish_clause(0);

        // Noise selects 4 mod 3; with noise disabled, greedy selects index 0.
        set_bv(0, 2); set_bv(1, 3); set_bv(2, 4);
        send_clause(3, 1'b1, 1'b1, 32'hFF000004);
        check_output("noise_const", 32'(selected_o), 32'd1);
        finish_clause(0);
        send_clause(3, 1'b1, 1'b0, 32'hFF000004);
        check_output("noise_off_const", 32'(selected_o), 32'd0);
        finish_clause(0);

        // Threshold boundary: random_i == P triggers noise, P-1 does not.
        send_clause(3, 1'b1, 1'b1, P_TB);
        finish_clause(0);
        send_clause(3, 1'b1, 1'b1, P_TB - 32'd1);
        finish_clause(0);

        // Single-candidate clause.
        set_bv(0, 7);
        send_clause(1, 1'b1, 1'b1, 32'hFFFFFFFF);
        finish_clause(0);

        // Two-candidate clause with a four-cycle stall.
        set_bv(0, 5); set_bv(1, 2);
        send_clause(2, 1'b1, 1'b0, 32'h0);
        check_output("two_cand_const", 32'(selected_o), 32'd1);
        finish_clause(4);

        // Reset after two accepts discards the partial clause and clears the
        // held result.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cand_valid_i    = 1'b1;
            cand_last_i     = 1'b0;
            clause_broken_i = 20'hFFFFF;
            mask_bits_i     = 20'hFFFFF;
        end
        @(negedge clk);
        cand_valid_i = 1'b0;
        reset        = 1'b0;
        #1 check_cleared("midreset");
        @(negedge clk);
        reset = 1'b1;
        set_bv(0, 1); set_bv(1, 6); set_bv(2, 2);
        send_clause(3, 1'b1, 1'b0, 32'h0);
        finish_clause(0);

        // Reset while a result is held in OUTPUT.
        set_bv(0, 3); set_bv(1, 2); set_bv(2, 5);
        send_clause(3, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        #1 check_cleared("outreset");
        @(negedge clk);
        reset = 1'b1;

        // Randomized clauses.
        for (int t = 0; t < 60; t++) begin
            int n;
            bit ne;
            bit last_f;
            logic [31:0] r;
            n = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 0) mk[k] = 20'($urandom & $urandom & $urandom);
                else mk[k] = 20'($urandom);
                cb[k] = 20'($urandom);
            end
            ne     = 1'($urandom_range(0, 1));
            r      = $urandom;
            last_f = (n < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            send_clause(n, last_f, ne, r);
            finish_clause($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/variable_flip_selector_k.md
VARIABLE_FLIP_SELECTOR_K -- requirements
Module: variable_flip_selector_k

Interface
REQ-001 SHALL have parameter MAX_CLAUSES_PER_VARIABLE, default 20, meaning clause slots per candidate variable (MC).
REQ-002 SHALL have parameter NSAT, default 3, legal range 2..8, meaning the maximum number of candidates per clause.
REQ-003 SHALL have parameter NSAT_BITS, default 2, meaning the width of the candidate index, equal to clog2(NSAT).
REQ-004 SHALL have parameter MAX_CLAUSES_PER_VARIABLE_BITS, default 5, meaning the width of a break value (MCB), at least clog2(MC+1).
REQ-005 SHALL have parameter P, default 32'h6E147AE0, meaning the noise threshold.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset.
REQ-008 SHALL have port cand_valid_i, input, 1 bit, meaning a candidate is presented.
REQ-009 SHALL have port cand_ready_o, output, 1 bit, meaning the block accepts a candidate.
REQ-010 SHALL have port cand_last_i, input, 1 bit, meaning the presented candidate is the final one of its clause.
REQ-011 SHALL have port clause_broken_i, input, MC bits, meaning per-slot broken-if-flipped flags.
REQ-012 SHALL have port mask_bits_i, input, MC bits, meaning per-slot occupancy mask.
REQ-013 SHALL have port noise_en_i, input, 1 bit, meaning random-walk selection is enabled.
REQ-014 SHALL have port random_i, input, 32 bits, meaning the LFSR word.
REQ-015 SHALL have port sel_valid_o, output, 1 bit, meaning a selection result is held.
REQ-016 SHALL have port sel_ready_i, input, 1 bit, meaning the consumer takes the result.
REQ-017 SHALL have port selected_o, output, NSAT_BITS bits, meaning the chosen candidate index.
REQ-018 SHALL have port break_value_o, output, MCB bits, meaning the break value of the chosen candidate.
REQ-019 SHALL have port clause_broken_bits_o, output, MC bits, meaning the masked broken bits of the chosen candidate.

Function
REQ-020 SHALL implement states COLLECT, DECIDE and OUTPUT.
REQ-021 SHALL drive cand_ready_o=1 only in COLLECT; an accept is cand_valid_i & cand_ready_o at a rising edge.
REQ-022 SHALL, on accept k (k counted from 0), store bits[k]=clause_broken_i & mask_bits_i and bv[k]=popcount(bits[k]), then increment count.
REQ-023 SHALL transition COLLECT->DECIDE on an accept with cand_last_i=1, or on the accept that makes count equal to NSAT (cand_last_i ignored in that case).
REQ-024 SHALL, in DECIDE, resolve the selection in one cycle using only indices below count, then enter OUTPUT.
REQ-025 SHALL apply priority 1 (zero override): if any bv equals 0, select the highest index whose bv is 0; noise is ignored.
REQ-026 SHALL apply priority 2 (noise): if noise_en_i=1 and random_i >= P (unsigned compare), select random_i[15:0] mod count.
REQ-027 SHALL apply priority 3 (greedy): otherwise select the minimum bv, with ties resolved to the highest index.
REQ-028 SHALL sample random_i and noise_en_i only in the DECIDE cycle.
REQ-029 SHALL register selected_o, break_value_o and clause_broken_bits_o at the DECIDE edge and hold them stable with sel_valid_o=1 throughout OUTPUT.
REQ-030 SHALL, in OUTPUT, return to COLLECT with count=0 on sel_ready_i=1, and stall indefinitely on sel_ready_i=0.
REQ-031 SHALL give latency: with the last accept at edge N, sel_valid_o is 1 after edge N+1; minimum clause period is count+2 cycles.
REQ-032 SHALL treat a single-candidate clause (cand_last_i=1 on the first accept) as count=1 and select index 0.
REQ-033 SHALL not make popcount saturate, since MCB holds MC.
REQ-034 SHALL keep the outputs of a completed clause stable while stalled, regardless of input activity.

Reset
REQ-035 SHALL, while reset=0, asynchronously force state=COLLECT, count=0, sel_valid_o=0, selected_o=0, break_value_o=0, clause_broken_bits_o=0 and all bv/bits storage to 0.
REQ-036 SHALL, on reset asserted mid-clause or in OUTPUT, discard the partial or held result; after release the first accept is index 0.

Verification
REQ-037 SHALL pass this scenario: NSAT=3, three candidates with all masks 0 -> selected_o=2, break_value_o=0, clause_broken_bits_o=0.
REQ-038 SHALL pass this scenario: bv={4,0,3}, noise_en_i=1, random_i=32'hFFFFFFFF -> selected_o=1 (zero override beats noise).
REQ-039 SHALL pass this scenario: bv={1,3,1}, random_i=0 -> selected_o=2, break_value_o=1 (greedy, highest tied index).
REQ-040 SHALL pass this scenario: bv={2,3,4}, noise_en_i=1, random_i=32'hFF000004 -> selected_o=1 (4 mod 3); same stimulus with noise_en_i=0 -> selected_o=0.
REQ-041 SHALL pass this scenario: a 2-candidate clause ends with cand_last_i=1, bv={5,2}, sel_ready_i held 0 for 4 cycles -> sel_valid_o=1 with selected_o=1 stable throughout, cand_ready_o=0, and COLLECT resumes one edge after sel_ready_i=1.
REQ-042 SHALL pass this scenario: reset=0 asserted after 2 accepts -> all outputs 0 immediately; a fresh 3-candidate clause afterwards decides correctly.
